hps_dpram_ctrl: RTL
===================

Name: hps_dpram_ctrl

Overview:
- Parametrised, single-clock, true dual-port on-chip RAM with two Avalon-MM slave ports (s1, s2).
- Generalises the fixed 128-bit x 1024 bidirectional RAM in three ways: configurable width and depth, a read pipeline with readdatavalid, and deterministic same-cycle collision and forwarding rules.
- Adds a post-reset clear sequencer that zeroes the whole array before either port is allowed in.
- Sits between the HPS bridges and fabric masters as a shared scratch buffer.

Parameters:
- DATA_W, 128: word width in bits. Must be a multiple of 8.
- ADDR_W, 10: address width. DEPTH = 2**ADDR_W.
- READ_LATENCY, 1: accept-to-readdatavalid latency in cycles. Legal values are 1 and 2.
- CLEAR_ON_RESET, 1: 1 = zero the array after reset; 0 = no clear.

Ports:
- clk  in  1  Single clock for both ports.
- reset  in  1  Synchronous, active-high reset.
- address / address2  in  ADDR_W  Word address, s1 / s2.
- byteenable / byteenable2  in  DATA_W/8  Byte-lane write enables.
- chipselect / chipselect2  in  1  Port select.
- read / read2  in  1  Read request.
- write / write2  in  1  Write request.
- writedata / writedata2  in  DATA_W  Write data.
- clken / clken2  in  1  Per-port clock enable; low = no acceptance.
- reset_req / reset_req2  in  1  High = no acceptance on that port.
- waitrequest / waitrequest2  out  1  High while clearing or while in reset.
- readdata / readdata2  out  DATA_W  Read data, registered.
- readdatavalid / readdatavalid2  out  1  One-cycle strobe marking valid readdata.

Behaviour:
- Reset (sampled on the clk edge while reset=1):
  - state <= CLEAR if CLEAR_ON_RESET=1, else RUN.
  - clr_addr <= 0.
  - readdata, readdata2 <= 0; readdatavalid, readdatavalid2 <= 0.
  - Read pipelines flushed.
  - RAM contents are not reset by reset itself.
- waitrequest = waitrequest2 = reset | (state==CLEAR).
- FSM CLEAR:
  - Each cycle writes all-zero, full byteenable, to clr_addr, then clr_addr++.
  - Runs regardless of clken and reset_req.
  - At clr_addr==DEPTH-1: write that address, then go to RUN. Clear lasts exactly DEPTH cycles.
  - Reset asserted mid-clear restarts the clear at address 0.
- FSM RUN: no exit except via reset.
- Port accept (per port, RUN only): chipselect & (read|write) & clken & ~reset_req. A request that is not accepted is ignored; the master must hold it under waitrequest.
- read and write asserted together: treated as a write only; no read response is produced.
- Write: for each lane i with byteenable[i]=1, mem[address][8i+7:8i] <= writedata lane i. Committed at the accept edge.
- Same-cycle write/write to the same address:
  - Lanes enabled on both ports take s1 data.
  - Lanes enabled on s2 only take s2 data.
  - No X, no dropped lanes.
- Read:
  - Returns mem[address] including all writes accepted in earlier cycles.
  - A same-cycle write by the other port to the same address is forwarded: enabled lanes show new data, other lanes show old.
- Read latency:
  - readdatavalid pulses exactly READ_LATENCY cycles after the accept edge, one pulse per accepted read.
  - Back-to-back reads give back-to-back valids, in order.
  - readdata holds its last value between valids.
- Dropping clken or raising reset_req blocks only new accepts; in-flight reads still complete.
- Out-of-range address is impossible: address width equals ADDR_W.

Test Plan:
- Reset with CLEAR_ON_RESET=1, DEPTH=1024 -> waitrequest=1 for 1024 cycles after reset deasserts, then 0. Read of 0x3FF returns 0 with readdatavalid at +1 cycle.
- s1 writes 0x...DEADBEEF to addr 5 with byteenable=0x000F; s2 reads addr 5 the next cycle -> readdata2 low 32 bits = 0xDEADBEEF, upper bits 0.
- Same cycle: s1 writes addr 9 with byteenable=0x00FF and data all-0x11; s2 writes addr 9 with byteenable=0xFF0F and data all-0x22 -> readback = 0x2222...22_1111111111111111 (bytes 15..8 = 0x22, bytes 7..0 = 0x11).
- READ_LATENCY=2: s1 reads addrs 0,1,2 on consecutive cycles -> readdatavalid high on cycles +2,+3,+4 with matching data, in order.
- s1 reads addr 7 while s2 writes 0xAA to byte 0 of addr 7 in the same cycle -> s1 readdata byte 0 = 0xAA, other bytes old.
- Assert reset at clear address 500 -> clear restarts at 0 and takes 1024 more cycles. Pulse clken=0 with an in-flight read -> that read's valid still arrives; the new request is ignored.

Source files
------------

// File: rtl/hps_dpram_ctrl.sv
// ============================================================================
// Module   : hps_dpram_ctrl
// Brief    : Parametrised true dual-port Avalon-MM scratch RAM with post-reset
//            clear, pipelined read responses and same-cycle forwarding.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hps_dpram_ctrl #(
    parameter int DATA_W         = 128,
    parameter int ADDR_W         = 10,
    parameter int READ_LATENCY   = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    // s1
    input  logic [ADDR_W-1:0]     address,
    input  logic [DATA_W/8-1:0]   byteenable,
    input  logic                  chipselect,
    input  logic                  read,
    input  logic                  write,
    input  logic [DATA_W-1:0]     writedata,
    input  logic                  clken,
    input  logic                  reset_req,
    output logic                  waitrequest,
    output logic [DATA_W-1:0]     readdata,
    output logic                  readdatavalid,
    // s2
    input  logic [ADDR_W-1:0]     address2,
    input  logic [DATA_W/8-1:0]   byteenable2,
    input  logic                  chipselect2,
    input  logic                  read2,
    input  logic                  write2,
    input  logic [DATA_W-1:0]     writedata2,
    input  logic                  clken2,
    input  logic                  reset_req2,
    output logic                  waitrequest2,
    output logic [DATA_W-1:0]     readdata2,
    output logic                  readdatavalid2
);

    localparam int                BE_W        = DATA_W / 8;
    localparam int                DEPTH       = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] C_LAST_ADDR = {ADDR_W{1'b1}};

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t             r_state;
    logic [ADDR_W-1:0]  r_clr_addr;
    logic [DATA_W-1:0]  r_mem [DEPTH];

    logic               w_run;
    logic               w_clr_we;
    logic               w_acc1, w_acc2;
    logic               w_wr1, w_wr2;
    logic               w_rd1, w_rd2;
    logic [DATA_W-1:0]  w_fwd1, w_fwd2;
    logic               w_out_vld1, w_out_vld2;
    logic [DATA_W-1:0]  w_out_dat1, w_out_dat2;

    // ------------------------------------------------------------------------
    // Clear sequencer
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            if (CLEAR_ON_RESET != 0) begin
                r_state <= ST_CLEAR;
            end else begin
                r_state <= ST_RUN;
            end
            r_clr_addr <= '0;
        end else if (r_state == ST_CLEAR) begin
            r_clr_addr <= r_clr_addr + 1'b1;
            if (r_clr_addr == C_LAST_ADDR) begin
                r_state <= ST_RUN;
            end
        end
    end

    assign waitrequest  = reset | (r_state == ST_CLEAR);
    assign waitrequest2 = reset | (r_state == ST_CLEAR);

    // ------------------------------------------------------------------------
    // Accept logic; a combined read+write is a write only
    // ------------------------------------------------------------------------
    assign w_run    = (r_state == ST_RUN) & ~reset;
    assign w_clr_we = (r_state == ST_CLEAR) & ~reset;

    assign w_acc1 = w_run & chipselect  & (read  | write)  & clken  & ~reset_req;
    assign w_acc2 = w_run & chipselect2 & (read2 | write2) & clken2 & ~reset_req2;
    assign w_wr1  = w_acc1 & write;
    assign w_wr2  = w_acc2 & write2;
    assign w_rd1  = w_acc1 & read  & ~write;
    assign w_rd2  = w_acc2 & read2 & ~write2;

    // ------------------------------------------------------------------------
    // Storage: s1 lanes are written last so they win on shared lanes
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_clr_we) begin
            r_mem[r_clr_addr] <= '0;
        end else begin
            for (int i = 0; i < BE_W; i++) begin
                if (w_wr2 && byteenable2[i]) begin
                    r_mem[address2][8*i +: 8] <= writedata2[8*i +: 8];
                end
            end
            for (int i = 0; i < BE_W; i++) begin
                if (w_wr1 && byteenable[i]) begin
                    r_mem[address][8*i +: 8] <= writedata[8*i +: 8];
                end
            end
        end
    end

    // Read path sees the other port's same-cycle write on its enabled lanes
    always_comb begin
        w_fwd1 = r_mem[address];
        w_fwd2 = r_mem[address2];
        for (int i = 0; i < BE_W; i++) begin
            if (w_wr2 && (address2 == address) && byteenable2[i]) begin
                w_fwd1[8*i +: 8] = writedata2[8*i +: 8];
            end
            if (w_wr1 && (address == address2) && byteenable[i]) begin
                w_fwd2[8*i +: 8] = writedata[8*i +: 8];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Read pipeline: optional extra stage ahead of the output registers
    // ------------------------------------------------------------------------
    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic              r_s_vld1, r_s_vld2;
            logic [DATA_W-1:0] r_s_dat1, r_s_dat2;

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_s_vld1 <= 1'b0;
                    r_s_vld2 <= 1'b0;
                    r_s_dat1 <= '0;
                    r_s_dat2 <= '0;
                end else begin
                    r_s_vld1 <= w_rd1;
                    r_s_vld2 <= w_rd2;
                    r_s_dat1 <= w_fwd1;
                    r_s_dat2 <= w_fwd2;
                end
            end

            assign w_out_vld1 = r_s_vld1;
            assign w_out_vld2 = r_s_vld2;
            assign w_out_dat1 = r_s_dat1;
            assign w_out_dat2 = r_s_dat2;
        end else begin : g_lat1
            assign w_out_vld1 = w_rd1;
            assign w_out_vld2 = w_rd2;
            assign w_out_dat1 = w_fwd1;
            assign w_out_dat2 = w_fwd2;
        end
    endgenerate

    // readdata only moves on a valid, so it holds between responses
    always_ff @(posedge clk) begin
        if (reset) begin
            readdata       <= '0;
            readdata2      <= '0;
            readdatavalid  <= 1'b0;
            readdatavalid2 <= 1'b0;
        end else begin
            readdatavalid  <= w_out_vld1;
            readdatavalid2 <= w_out_vld2;
            if (w_out_vld1) begin
                readdata <= w_out_dat1;
            end
            if (w_out_vld2) begin
                readdata2 <= w_out_dat2;
            end
        end
    end

endmodule

`default_nettype wire
